// File: rtl/cnn_seq_pkg.sv
// Shared types for the CNN layer sequencer: op codes, FSM states, command
// payload and the op-to-engine one-hot decode.
package cnn_seq_pkg;

    localparam int unsigned NUM_ENGINES = 4;

    typedef enum logic [1:0] {
        OP_CONV     = 2'd0,
        OP_BIASRELU = 2'd1,
        OP_POOL     = 2'd2,
        OP_FULL     = 2'd3
    } cnnOp_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } seqState_e;

    typedef struct packed {
        cnnOp_e op;
        logic   last;
    } cmd_t;

    // Bit n of the result selects engine n (Conv, BiasReLU, Pool, Full).
    function automatic logic [NUM_ENGINES-1:0] opOneHot(cnnOp_e op);
        opOneHot = NUM_ENGINES'(1) << op;
    endfunction

endpackage

// File: rtl/cnn_layer_sequencer_if.sv
// Command push channel plus the four engine Req/Ack pairs of the sequencer.
interface cnn_layer_sequencer_if;

    logic       CmdValid_i;
    logic       CmdReady_o;
    logic [1:0] CmdOp_i;
    logic       CmdLast_i;

    logic ConvReq_o;
    logic BiasReLUReq_o;
    logic PoolReq_o;
    logic FullReq_o;

    logic ConvAck_i;
    logic BiasReLUAck_i;
    logic PoolAck_i;
    logic FullAck_i;

    // Host and engines side.
    modport master (
        output CmdValid_i, CmdOp_i, CmdLast_i,
        output ConvAck_i, BiasReLUAck_i, PoolAck_i, FullAck_i,
        input  CmdReady_o,
        input  ConvReq_o, BiasReLUReq_o, PoolReq_o, FullReq_o
    );

    // Sequencer side.
    modport slave (
        input  CmdValid_i, CmdOp_i, CmdLast_i,
        input  ConvAck_i, BiasReLUAck_i, PoolAck_i, FullAck_i,
        output CmdReady_o,
        output ConvReq_o, BiasReLUReq_o, PoolReq_o, FullReq_o
    );

endinterface

// File: rtl/seq_cmd_fifo.sv
// Synchronous command FIFO with flush, occupancy level and full/empty flags.
module seq_cmd_fifo
    import cnn_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  cmd_t                     wrData,
    output cmd_t                     rdData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign full   = (level == LVL_W'(DEPTH));
    assign empty  = (level == '0);
    assign doPush = push & ~full;
    assign doPop  = pop & ~empty;
    assign rdData = mem[rdPtr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({doPush, doPop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !flush) mem[wrPtr] <= wrData;
    end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Steps a queued program of CNN stage ops through the four engines, one
// Req pulse per op, advancing on the matching Ack with an optional timeout.
module cnn_layer_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned TIMEOUT_W = 24,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    cnn_layer_sequencer_if.slave   bus,
    input  logic                   Start_i,
    input  logic                   Abort_i,
    input  logic [TIMEOUT_W-1:0]   TimeoutCycles_i,
    output logic                   Busy_o,
    output logic                   Done_o,
    output logic                   Timeout_o,
    output logic [CNT_W-1:0]       OpCnt_o,
    output logic [$clog2(DEPTH):0] FifoLevel_o
);

    seqState_e              state;
    cmd_t                   curCmd;
    cmd_t                   headCmd;
    cmd_t                   wrCmd;
    logic [TIMEOUT_W-1:0]   timer;
    logic                   timerEn;
    logic [NUM_ENGINES-1:0] reqVec;
    logic [NUM_ENGINES-1:0] ackVec;
    logic                   ackHit;
    logic                   fifoFull;
    logic                   fifoEmpty;
    logic                   pushCmd;
    logic                   popCmd;

    assign wrCmd.op   = cnnOp_e'(bus.CmdOp_i);
    assign wrCmd.last = bus.CmdLast_i;

    assign bus.CmdReady_o = ~fifoFull;
    assign pushCmd        = bus.CmdValid_i & ~fifoFull;

    assign ackVec = {bus.FullAck_i, bus.PoolAck_i, bus.BiasReLUAck_i, bus.ConvAck_i};
    assign ackHit = |(ackVec & opOneHot(curCmd.op));
    assign popCmd = (state == WAIT) & ackHit & ~Abort_i;

    assign bus.ConvReq_o     = reqVec[0];
    assign bus.BiasReLUReq_o = reqVec[1];
    assign bus.PoolReq_o     = reqVec[2];
    assign bus.FullReq_o     = reqVec[3];

    seq_cmd_fifo #(
        .DEPTH (DEPTH)
    ) uFifo (
        .clk    (clk),
        .rstn   (rstn),
        .flush  (Abort_i),
        .push   (pushCmd),
        .pop    (popCmd),
        .wrData (wrCmd),
        .rdData (headCmd),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .level  (FifoLevel_o)
    );

    // Sequencer FSM; Req and Done are set on the edge that enters ISSUE/DONE.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            curCmd    <= '0;
            timer     <= '0;
            timerEn   <= 1'b0;
            reqVec    <= '0;
            Busy_o    <= 1'b0;
            Done_o    <= 1'b0;
            Timeout_o <= 1'b0;
            OpCnt_o   <= '0;
        end else begin
            reqVec <= '0;
            Done_o <= 1'b0;
            if (Abort_i) begin
                state     <= IDLE;
                Busy_o    <= 1'b0;
                Timeout_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (Start_i && !fifoEmpty) begin
                            state     <= FETCH;
                            Busy_o    <= 1'b1;
                            OpCnt_o   <= '0;
                            Timeout_o <= 1'b0;
                        end
                    end
                    FETCH: begin
                        if (!fifoEmpty) begin
                            curCmd  <= headCmd;
                            reqVec  <= opOneHot(headCmd.op);
                            timer   <= TimeoutCycles_i;
                            timerEn <= |TimeoutCycles_i;
                            state   <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (timer != '0) timer <= timer - TIMEOUT_W'(1);
                        state <= WAIT;
                    end
                    WAIT: begin
                        if (ackHit) begin
                            OpCnt_o <= OpCnt_o + CNT_W'(1);
                            if (curCmd.last) begin
                                state  <= DONE;
                                Done_o <= 1'b1;
                            end else begin
                                state <= FETCH;
                            end
                        end else if (timerEn && timer <= TIMEOUT_W'(1)) begin
                            state     <= ERR;
                            Timeout_o <= 1'b1;
                        end else if (timer != '0) begin
                            timer <= timer - TIMEOUT_W'(1);
                        end
                    end
                    DONE: begin
                        state  <= IDLE;
                        Busy_o <= 1'b0;
                    end
                    ERR: begin
                        // Head entry was never popped, so FETCH retries it.
                        if (Start_i) begin
                            state     <= FETCH;
                            Timeout_o <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        Busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Scoreboard bench for cnn_layer_sequencer: stimulus queues expected Req/Done/
// Timeout events with their cycle, a negedge monitor pops and compares them.
module tb_cnn_layer_sequencer;
    import cnn_seq_pkg::*;

    localparam int unsigned DEPTH     = 16;
    localparam int unsigned TIMEOUT_W = 24;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned LVL_W     = $clog2(DEPTH) + 1;

    localparam int EV_REQ  = 0;
    localparam int EV_DONE = 1;
    localparam int EV_TO   = 2;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 Start_i = 1'b0;
    logic                 Abort_i = 1'b0;
    logic [TIMEOUT_W-1:0] TimeoutCycles_i = '0;
    logic                 Busy_o;
    logic                 Done_o;
    logic                 Timeout_o;
    logic [CNT_W-1:0]     OpCnt_o;
    logic [LVL_W-1:0]     FifoLevel_o;

    cnn_layer_sequencer_if bus();

    cnn_layer_sequencer #(
        .DEPTH     (DEPTH),
        .TIMEOUT_W (TIMEOUT_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .bus             (bus),
        .Start_i         (Start_i),
        .Abort_i         (Abort_i),
        .TimeoutCycles_i (TimeoutCycles_i),
        .Busy_o          (Busy_o),
        .Done_o          (Done_o),
        .Timeout_o       (Timeout_o),
        .OpCnt_o         (OpCnt_o),
        .FifoLevel_o     (FifoLevel_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t  expQ[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic monOn = 1'b0;
    logic prevTo = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chkEvent(input int kind, input int val);
        ev_t e;
        vectors++;
        if (expQ.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got kind=%0d val=%0d at cycle %0d, expected none",
                     kind, val, cyc);
        end else begin
            e = expQ.pop_front();
            if (e.kind != kind || e.val != val || e.cyc != cyc) begin
                miscompares++;
                $display("FAIL event: got kind=%0d val=%0d cycle=%0d expected kind=%0d val=%0d cycle=%0d",
                         kind, val, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    // Monitor: every Req pulse, Done pulse and Timeout rise is an observed event.
    always @(negedge clk) begin
        if (monOn) begin
            if (bus.ConvReq_o === 1'b1)     chkEvent(EV_REQ, 0);
            if (bus.BiasReLUReq_o === 1'b1) chkEvent(EV_REQ, 1);
            if (bus.PoolReq_o === 1'b1)     chkEvent(EV_REQ, 2);
            if (bus.FullReq_o === 1'b1)     chkEvent(EV_REQ, 3);
            if (Done_o === 1'b1)            chkEvent(EV_DONE, int'(OpCnt_o));
            if (Timeout_o === 1'b1 && prevTo !== 1'b1) chkEvent(EV_TO, 0);
            prevTo = Timeout_o;
        end
    end

    task automatic expectEv(input int kind, input int val, input int atCyc);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = atCyc;
        expQ.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic stepTo(input int t);
        while (cyc < t) step(1);
    endtask

    task automatic pushCmd(input int op, input logic last);
        bus.CmdValid_i = 1'b1;
        bus.CmdOp_i    = 2'(op);
        bus.CmdLast_i  = last;
        step(1);
        bus.CmdValid_i = 1'b0;
        bus.CmdLast_i  = 1'b0;
    endtask

    task automatic setAcks(input logic [3:0] mask);
        bus.ConvAck_i     = mask[0];
        bus.BiasReLUAck_i = mask[1];
        bus.PoolAck_i     = mask[2];
        bus.FullAck_i     = mask[3];
    endtask

    task automatic ackPulse(input logic [3:0] mask);
        setAcks(mask);
        step(1);
        setAcks(4'b0000);
    endtask

    task automatic startPulse(output int startCyc);
        startCyc = cyc;
        Start_i  = 1'b1;
        step(1);
        Start_i  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int r;
        int a;
        logic [3:0] m;

        bus.CmdValid_i = 1'b0;
        bus.CmdOp_i    = 2'd0;
        bus.CmdLast_i  = 1'b0;
        setAcks(4'b0000);

        step(3);
        rstn = 1'b1;
        step(1);
        monOn = 1'b1;

        // Reset state
        chk("rst_busy", int'(Busy_o), 0);
        chk("rst_done", int'(Done_o), 0);
        chk("rst_timeout", int'(Timeout_o), 0);
        chk("rst_opcnt", int'(OpCnt_o), 0);
        chk("rst_level", int'(FifoLevel_o), 0);
        chk("rst_ready", int'(bus.CmdReady_o), 1);
        chk("rst_reqs", int'({bus.FullReq_o, bus.PoolReq_o, bus.BiasReLUReq_o, bus.ConvReq_o}), 0);

        // Start with an empty FIFO is ignored
        startPulse(s);
        step(2);
        chk("empty_start_busy", int'(Busy_o), 0);

        // Four-op program, each Ack 5 cycles after its Req
        pushCmd(0, 1'b0);
        pushCmd(1, 1'b0);
        pushCmd(2, 1'b0);
        pushCmd(3, 1'b1);
        chk("prog_level", int'(FifoLevel_o), 4);
        startPulse(s);
        chk("prog_busy", int'(Busy_o), 1);
        r = s + 2;
        for (int i = 0; i < 4; i++) begin
            expectEv(EV_REQ, i, r);
            stepTo(r + 5);
            a = cyc;
            if (i == 3) expectEv(EV_DONE, 4, a + 1);
            m = 4'b0001 << i;
            ackPulse(m);
            r = a + 2;
        end
        step(3);
        chk("prog_opcnt", int'(OpCnt_o), 4);
        chk("prog_busy_end", int'(Busy_o), 0);
        chk("prog_level_end", int'(FifoLevel_o), 0);

        // Ack timeout then retry of the same head entry
        TimeoutCycles_i = TIMEOUT_W'(10);
        pushCmd(2, 1'b1);
        startPulse(s);
        r = s + 2;
        expectEv(EV_REQ, 2, r);
        expectEv(EV_TO, 0, r + 10);
        stepTo(r + 12);
        chk("to_sticky", int'(Timeout_o), 1);
        chk("to_busy", int'(Busy_o), 1);
        chk("to_level", int'(FifoLevel_o), 1);
        startPulse(s);
        chk("to_cleared", int'(Timeout_o), 0);
        r = s + 2;
        expectEv(EV_REQ, 2, r);
        stepTo(r + 3);
        a = cyc;
        expectEv(EV_DONE, 1, a + 1);
        ackPulse(4'b0100);
        step(3);
        chk("retry_level", int'(FifoLevel_o), 0);
        TimeoutCycles_i = '0;

        // FIFO full, overflow drop, push+pop same cycle
        for (int i = 0; i < 16; i++) pushCmd(i % 4, 1'b0);
        chk("full_level", int'(FifoLevel_o), 16);
        chk("full_ready", int'(bus.CmdReady_o), 0);
        pushCmd(3, 1'b1);
        chk("overflow_level", int'(FifoLevel_o), 16);
        startPulse(s);
        r = s + 2;
        expectEv(EV_REQ, 0, r);
        stepTo(r + 1);
        a = cyc;
        ackPulse(4'b0001);
        chk("pop_level", int'(FifoLevel_o), 15);
        r = a + 2;
        expectEv(EV_REQ, 1, r);
        stepTo(r + 1);
        bus.CmdValid_i = 1'b1;
        bus.CmdOp_i    = 2'd0;
        bus.CmdLast_i  = 1'b0;
        setAcks(4'b0010);
        step(1);
        bus.CmdValid_i = 1'b0;
        setAcks(4'b0000);
        chk("pushpop_level", int'(FifoLevel_o), 15);
        chk("pushpop_ready", int'(bus.CmdReady_o), 1);
        Abort_i = 1'b1;
        step(1);
        Abort_i = 1'b0;
        chk("abort_flush_level", int'(FifoLevel_o), 0);
        chk("abort_flush_busy", int'(Busy_o), 0);
        step(4);

        // Non-matching Acks and an Ack during the Req cycle are ignored
        pushCmd(0, 1'b0);
        pushCmd(2, 1'b1);
        startPulse(s);
        r = s + 2;
        expectEv(EV_REQ, 0, r);
        stepTo(r);
        ackPulse(4'b0001);
        stepTo(r + 2);
        ackPulse(4'b1100);
        stepTo(r + 4);
        ackPulse(4'b0001);
        expectEv(EV_REQ, 2, r + 6);
        stepTo(r + 8);
        expectEv(EV_DONE, 2, r + 9);
        ackPulse(4'b0100);
        step(3);
        chk("mismatch_opcnt", int'(OpCnt_o), 2);

        // Abort in the same cycle as the matching Ack
        pushCmd(0, 1'b0);
        pushCmd(3, 1'b1);
        startPulse(s);
        r = s + 2;
        expectEv(EV_REQ, 0, r);
        stepTo(r + 3);
        Abort_i = 1'b1;
        setAcks(4'b0001);
        step(1);
        Abort_i = 1'b0;
        setAcks(4'b0000);
        step(6);
        chk("abortack_level", int'(FifoLevel_o), 0);
        chk("abortack_busy", int'(Busy_o), 0);
        chk("abortack_opcnt", int'(OpCnt_o), 0);

        // FETCH holds on an empty FIFO until the next command arrives
        pushCmd(0, 1'b0);
        startPulse(s);
        r = s + 2;
        expectEv(EV_REQ, 0, r);
        stepTo(r + 2);
        a = cyc;
        ackPulse(4'b0001);
        stepTo(a + 5);
        chk("fetch_hold_busy", int'(Busy_o), 1);
        chk("fetch_hold_opcnt", int'(OpCnt_o), 1);
        a = cyc;
        expectEv(EV_REQ, 3, a + 2);
        pushCmd(3, 1'b1);
        stepTo(a + 4);
        expectEv(EV_DONE, 2, a + 5);
        ackPulse(4'b1000);
        step(3);
        chk("fetch_hold_done_busy", int'(Busy_o), 0);

        // Synchronous reset mid-operation
        pushCmd(1, 1'b1);
        startPulse(s);
        r = s + 2;
        expectEv(EV_REQ, 1, r);
        stepTo(r + 1);
        rstn = 1'b0;
        step(1);
        rstn = 1'b1;
        chk("midrst_busy", int'(Busy_o), 0);
        chk("midrst_level", int'(FifoLevel_o), 0);
        chk("midrst_ready", int'(bus.CmdReady_o), 1);
        ackPulse(4'b0010);
        step(3);
        chk("midrst_opcnt", int'(OpCnt_o), 0);

        step(5);
        while (expQ.size() > 0) begin
            ev_t e;
            e = expQ.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_event: got nothing, expected kind=%0d val=%0d cycle=%0d",
                     e.kind, e.val, e.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
